// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus (CDB).
// Picks at most one eligible result producer per cycle, returns a one-hot
// accept in the same cycle, and drives the registered broadcast one cycle later.
//
// Ports:
//   clk        system clock, rising edge
//   nRST       asynchronous active-low reset
//   require    per-unit result-pending request (0=alu, 1=mul, 2=div, 3=ls)
//   dataIn     per-unit result, unit i at [i*DATA_W +: DATA_W]
//   labelIn    per-unit tag, unit i at [i*LABEL_W +: LABEL_W]; tag 0 is illegal
//   requireAC  one-hot accept, combinational
//   BCEN       registered broadcast valid
//   BCdata     registered broadcast data
//   BClabel    registered broadcast tag
//   grantId    registered index of the unit that was broadcast
//   badLabel   sticky flag: a request carried tag 0
module cdb_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic [N-1:0]           require,
  input  logic [N*DATA_W-1:0]    dataIn,
  input  logic [N*LABEL_W-1:0]   labelIn,
  output logic [N-1:0]           requireAC,
  output logic                   BCEN,
  output logic [DATA_W-1:0]      BCdata,
  output logic [LABEL_W-1:0]     BClabel,
  output logic [1:0]             grantId,
  output logic                   badLabel
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GID_W = 2;

  logic [PTR_W-1:0]   ptr;
  logic [N-1:0]       eligible_c;
  logic [N-1:0]       bad_req_c;
  logic               win_vld_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic [DATA_W-1:0]  win_data_c;
  logic [LABEL_W-1:0] win_label_c;
  int unsigned        scan;

  // A request is eligible only with a non-zero tag; tag-0 requests are flagged.
  always_comb begin
    eligible_c = '0;
    bad_req_c  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      eligible_c[i] = require[i] & (|labelIn[i*LABEL_W +: LABEL_W]);
      bad_req_c[i]  = require[i] & ~(|labelIn[i*LABEL_W +: LABEL_W]);
    end
  end

  // Rotating-priority scan starting at ptr; first eligible index wins.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    scan      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan = 32'(ptr) + k;
      if (scan >= N) begin
        scan = scan - N;
      end
      if (!win_vld_c && eligible_c[PTR_W'(scan)]) begin
        win_vld_c = 1'b1;
        win_idx_c = PTR_W'(scan);
      end
    end
  end

  // Winner payload mux.
  always_comb begin
    win_data_c  = '0;
    win_label_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_idx_c == PTR_W'(i)) begin
        win_data_c  = dataIn[i*DATA_W +: DATA_W];
        win_label_c = labelIn[i*LABEL_W +: LABEL_W];
      end
    end
  end

  // Accept is forced low while reset is asserted so pending requests are discarded.
  always_comb begin
    requireAC = '0;
    if (nRST && win_vld_c) begin
      requireAC[win_idx_c] = 1'b1;
    end
  end

  // Broadcast register, round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      BCEN     <= 1'b0;
      BCdata   <= '0;
      BClabel  <= '0;
      grantId  <= '0;
      badLabel <= 1'b0;
      ptr      <= '0;
    end else begin
      if (win_vld_c) begin
        BCEN    <= 1'b1;
        BCdata  <= win_data_c;
        BClabel <= win_label_c;
        grantId <= GID_W'(win_idx_c);
        if (win_idx_c == PTR_W'(N - 1)) begin
          ptr <= '0;
        end else begin
          ptr <= win_idx_c + PTR_W'(1);
        end
      end else begin
        BCEN <= 1'b0;
      end
      if (|bad_req_c) begin
        badLabel <= 1'b1;
      end
    end
  end

endmodule
